wave_pwm_out: RTL
=================

Name: wave_pwm_out

Overview:
Output-side consumer of the oscillator's 8-bit phase count. Samples that phase safely into the clk domain and shapes it into a saw, square or triangle sample. Attenuates the sample by a volume shift, then drives a 1-bit PWM audio pin. The shaped sample is loaded only at PWM-period boundaries, so the duty cycle never changes mid-period.

Parameters:
PWM_BITS, 8, width of PWM counter and duty register; the PWM period is 2^PWM_BITS clk cycles.

Ports:
clk  input  1  system clock
nRst  input  1  reset; asynchronous, active-low
enable  input  1  voice enable; low forces idle/cleared state
phase  input  8  phase count from the oscillator; changes asynchronously to clk
wave_sel  input  2  waveform: 0=saw, 1=square, 2=triangle, 3=off
volume  input  3  attenuation; sample right-shifted by this amount (0=full)
sample  output  8  shaped, attenuated sample currently held in the duty register
sample_valid  output  1  one-cycle pulse when a new duty value is loaded
pwm_out  output  1  PWM audio output

Behaviour:
- Reset (nRst low, async): all internal and output state is cleared.
  - sync1, sync2, accepted phase, pending, duty and PWM counter = 0.
  - sample=0, sample_valid=0, pwm_out=0.
- enable low (synchronous, every clk): same clear as reset. Counter is held at 0 and pwm_out=0.
- Phase capture (async input):
  - Two-flop synchroniser: sync1<=phase, sync2<=sync1.
  - A value is accepted only when sync2==sync1 (stable for 2 clks) and sync2!=accepted.
  - On acceptance: accepted<=sync2, and pending<=shape(sync2)>>volume in the same clk.
  - Latency from a stable phase change to pending updated: 3 clk edges.
  - Multiple accepted values within one PWM period: the last one wins; no queueing.
- Shaping, p = accepted phase:
  - saw: p.
  - square: p[7] ? 8'hFF : 8'h00.
  - triangle: p[7]==0 ? {p[6:0],1'b0} : {~p[6:0],1'b1}.
  - off: 8'h00.
- Attenuation: logical right shift by volume (0..7). No rounding; result stays 8-bit.
- wave_sel and volume changes take effect at the next phase acceptance. An unchanged phase does not re-evaluate pending.
- PWM counter: free-running 0..2^PWM_BITS-1 while enable=1, wrapping to 0.
- Duty load:
  - On the clk where the counter wraps from max to 0: duty<=pending, sample<=pending, sample_valid=1 for exactly that cycle.
  - The pulse occurs every period, even if the value is unchanged.
  - If acceptance and wrap happen on the same clk, duty takes the old pending; the new value loads at the following wrap.
- pwm_out is registered: pwm_out<=(next counter < duty).
  - duty=0: always low.
  - duty=255: high for 255 of 256 cycles (never 100%).
  - High count per period equals duty exactly.
- Enable rising: counter starts at 0, first wrap after 256 clks. Output stays low until the first sample_valid.
- Reset asserted mid-period: outputs clear immediately. After release, behaviour matches the first period after reset.

Test Plan:
- Reset then enable=1, phase held 0, saw, volume=0 -> pwm_out low for every period; sample_valid pulses every 256 clks; sample=0.
- phase=8'h80, saw, volume=0 -> after ≤3 clks plus the next wrap, sample=8'h80 and exactly 128 high cycles per period.
- phase sweep 0x40 then 0xC0, triangle -> samples 0x80 then 0x7F; square with 0xC0 -> 0xFF, giving 255 high cycles per period.
- phase=0xFF, saw, volume=3 -> sample=0x1F (31 high cycles); phase glitching each clk (never stable 2 clks) -> no acceptance, sample unchanged.
- Phase accepted on the same clk as a wrap -> duty keeps the old value for one period, new value at the following sample_valid.
- nRst pulsed low mid-period with duty=0x80 -> pwm_out, sample, sample_valid go 0 asynchronously; first valid reload 256 clks after release.

Source files
------------

// File: rtl/wave_pwm_out.sv
// Output stage of the voice: synchronises the oscillator phase into clk, shapes and
// attenuates it, and drives a period-aligned 1-bit PWM audio pin.
module wave_pwm_out #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        enable,
  input  logic [7:0]  phase,
  input  logic [1:0]  wave_sel,
  input  logic [2:0]  volume,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic        pwm_out
);

  localparam int unsigned SAMPLE_W = 8;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [SAMPLE_W-1:0] sync1, sync2, accepted, pending;
  logic [SAMPLE_W-1:0] shaped, pend_next;
  logic [PWM_BITS-1:0] cnt, cnt_next, duty, duty_next;
  logic                accept, wrap;

  // Waveform shaping of the synchronised phase, then volume attenuation
  always_comb begin
    shaped = 8'h00;
    case (wave_sel)
      2'd0:    shaped = sync2;
      2'd1:    shaped = sync2[7] ? 8'hFF : 8'h00;
      2'd2:    shaped = sync2[7] ? {~sync2[6:0], 1'b1} : {sync2[6:0], 1'b0};
      default: shaped = 8'h00;
    endcase
    pend_next = shaped >> volume;
  end

  // Accept only a phase that has been stable for two clks and is actually new
  assign accept    = (sync2 == sync1) && (sync2 != accepted);
  assign wrap      = (cnt == CNT_MAX);
  assign cnt_next  = cnt + PWM_BITS'(1);
  assign duty_next = wrap ? PWM_BITS'(pending) : duty;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1        <= '0;
      sync2        <= '0;
      accepted     <= '0;
      pending      <= '0;
      cnt          <= '0;
      duty         <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      pwm_out      <= 1'b0;
    end else if (!enable) begin
      sync1        <= '0;
      sync2        <= '0;
      accepted     <= '0;
      pending      <= '0;
      cnt          <= '0;
      duty         <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      sync1 <= phase;
      sync2 <= sync1;
      if (accept) begin
        accepted <= sync2;
        pending  <= pend_next;
      end
      cnt  <= cnt_next;
      duty <= duty_next;
      // Duty only changes at the period boundary; pending read here is pre-acceptance
      if (wrap) sample <= pending;
      sample_valid <= wrap;
      pwm_out      <= (cnt_next < duty_next);
    end
  end

endmodule
